// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;

    // Encoding that decode treats as a bubble.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default PC loaded on reset; the top level exposes it as a parameter.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // RUN: fetching at PC. HOLD: one fetched word parked while ID stalls.
    // DRAIN: a redirect arrived mid-access; finish and drop that access.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_t;

    // Contents of the IF/ID register and of the stall buffer.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] npc;
    } ifid_t;

endpackage

// File: rtl/if_pc_next.sv
// Redirect decode: redirect qualifier, prioritised target, and PC+4.
// Latency: purely combinational.
// Backpressure: redirects are suppressed while the stage is stalled.
module if_pc_next
    import if_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        pc_ifwrite,
    input  logic        z,
    input  logic        j,
    input  logic        jr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] jr_addr,
    output logic        redir,
    output logic [31:0] target,
    output logic [31:0] pc_plus4
);

    // A stalled ID stage must not change the fetch stream.
    assign redir = pc_ifwrite & (jr | j | z);

    // Wraps modulo 2^32 by construction.
    assign pc_plus4 = pc + 32'd4;

    // Jump-register wins over jump, jump wins over branch.
    always_comb begin
        target = branch_addr;
        if (jr) begin
            target = jr_addr;
        end else if (j) begin
            target = jump_addr;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: PC register, imem request sequencing, IF/ID register.
// Latency: word accepted with imem_ready in cycle n is in IF/ID in cycle n+1.
// Backpressure: PC_IFWrite=0 parks one fetched word and drops imem_req.
// Optional build macro IF_DELAY_SLOT_EN: the word at the current PC still
// enters IF/ID on a redirect instead of being squashed.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_IFWrite,
    input  logic        Z,
    input  logic        J,
    input  logic        JR,
    input  logic [31:0] BranchAddr,
    input  logic [31:0] JumpAddr,
    input  logic [31:0] JrAddr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] Instruction_id,
    output logic [31:0] NextPC_id
);

    if_state_t   state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend, pend_nxt;
    ifid_t       ifid, ifid_nxt;
    ifid_t       buf_q, buf_nxt;

`ifdef IF_DELAY_SLOT_EN
    // Redirect target waiting for its delay-slot word to reach IF/ID.
    logic        pend_vld, pend_vld_nxt;
`endif

    logic        redir;
    logic        fetched;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    ifid_t       fetched_word;
    ifid_t       bubble;

    if_pc_next u_pc_next (
        .pc          (pc),
        .pc_ifwrite  (PC_IFWrite),
        .z           (Z),
        .j           (J),
        .jr          (JR),
        .branch_addr (BranchAddr),
        .jump_addr   (JumpAddr),
        .jr_addr     (JrAddr),
        .redir       (redir),
        .target      (target),
        .pc_plus4    (pc_plus4)
    );

    // PC only changes when an access completes or none is in flight, so the
    // address is naturally stable across wait states.
    assign imem_req     = !reset && (state != HOLD);
    assign imem_addr    = pc;
    assign fetched      = imem_req && imem_ready;
    assign fetched_word = {imem_rdata, pc_plus4};
    // A bubble keeps the last NextPC so decode sees a consistent link value.
    assign bubble       = {NOP_INSTR, ifid.npc};

    assign Instruction_id = ifid.instr;
    assign NextPC_id      = ifid.npc;

    // Next-state, next-PC and IF/ID update for every state.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        pend_nxt  = pend;
        ifid_nxt  = ifid;
        buf_nxt   = buf_q;
`ifdef IF_DELAY_SLOT_EN
        pend_vld_nxt = pend_vld;
`endif
        case (state)
            RUN: begin
`ifdef IF_DELAY_SLOT_EN
                if (fetched && PC_IFWrite) begin
                    // The word at PC always enters IF/ID; it is the slot if
                    // a redirect is live now or was latched earlier.
                    ifid_nxt     = fetched_word;
                    pend_vld_nxt = 1'b0;
                    if (redir) begin
                        pc_nxt = target;
                    end else if (pend_vld) begin
                        pc_nxt = pend;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end else if (fetched) begin
                    buf_nxt   = fetched_word;
                    state_nxt = HOLD;
                end else if (PC_IFWrite) begin
                    ifid_nxt = bubble;
                    if (redir) begin
                        pend_nxt     = target;
                        pend_vld_nxt = 1'b1;
                    end
                end
`else
                if (redir) begin
                    ifid_nxt = bubble;
                    if (fetched) begin
                        pc_nxt = target;
                    end else begin
                        // Access still in flight: let it finish, then drop it.
                        pend_nxt  = target;
                        state_nxt = DRAIN;
                    end
                end else if (fetched && PC_IFWrite) begin
                    ifid_nxt = fetched_word;
                    pc_nxt   = pc_plus4;
                end else if (fetched) begin
                    buf_nxt   = fetched_word;
                    state_nxt = HOLD;
                end else if (PC_IFWrite) begin
                    ifid_nxt = bubble;
                end
`endif
            end
            HOLD: begin
                if (PC_IFWrite) begin
                    state_nxt = RUN;
                    buf_nxt   = '0;
`ifdef IF_DELAY_SLOT_EN
                    ifid_nxt     = buf_q;
                    pend_vld_nxt = 1'b0;
                    if (redir) begin
                        pc_nxt = target;
                    end else if (pend_vld) begin
                        pc_nxt = pend;
                    end else begin
                        pc_nxt = pc_plus4;
                    end
`else
                    if (redir) begin
                        ifid_nxt = bubble;
                        pc_nxt   = target;
                    end else begin
                        ifid_nxt = buf_q;
                        pc_nxt   = pc_plus4;
                    end
`endif
                end
            end
            DRAIN: begin
                if (PC_IFWrite) begin
                    ifid_nxt = bubble;
                end
                // A newer redirect replaces the one being waited on.
                if (redir) begin
                    pend_nxt = target;
                end
                if (fetched) begin
                    pc_nxt    = redir ? target : pend;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State, PC, buffer and IF/ID registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
            pend  <= '0;
            ifid  <= '0;
            buf_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            pend  <= pend_nxt;
            ifid  <= ifid_nxt;
            buf_q <= buf_nxt;
        end
    end

`ifdef IF_DELAY_SLOT_EN
    // Pending-slot flag for the delay-slot build.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_vld <= 1'b0;
        end else begin
            pend_vld <= pend_vld_nxt;
        end
    end
`endif

endmodule
